slice_encoder: RTL and testbench

Slice-layer bitstream writer, the transmit-side counterpart of the slice decoder in the camera path.
- Latches slice header fields on start and Exp-Golomb encodes them MSB-first.
- Bit-appends a byte-streamed slice payload after the header, then appends RBSP trailing bits.
- Emits the resulting NAL payload as a byte stream with valid/ready handshake toward the NAL packer.

---
 rtl/slice_codec_pkg.sv | 38 +++
 rtl/exp_golomb_encoder.sv | 29 ++
 rtl/slice_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_slice_encoder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slice_codec_pkg.sv
// Shared slice-layer codec definitions, used by both the encoder and the
// decoder side of the camera path.
//   slice_type_e : slice type encoding written as the first header codeword
//   *_W          : header field widths
//   MAX_CW_LEN   : longest Exp-Golomb codeword the header can produce
//   EPB_BYTE     : emulation-prevention byte value
//   se_code_num  : signed se(v) value -> ue code number
package slice_codec_pkg;

  typedef enum logic [1:0] {
    SLICE_P = 2'd0,
    SLICE_B = 2'd1,
    SLICE_I = 2'd2
  } slice_type_e;

  localparam logic [1:0]  SLICE_TYPE_ILLEGAL = 2'd3;

  localparam int unsigned SLICE_TYPE_W = 2;
  localparam int unsigned NUM_REF_W    = 3;
  localparam int unsigned QP_DELTA_W   = 6;
  localparam int unsigned CODE_NUM_W   = 7;
  localparam int unsigned CW_LEN_W     = 4;
  localparam int unsigned MAX_CW_LEN   = 13;

  localparam logic [7:0]  EPB_BYTE     = 8'h03;

  // se(v): 2v-1 for v>0, -2v for v<=0. Range -32..31 maps to 0..64.
  function automatic logic [CODE_NUM_W-1:0] se_code_num(input logic [QP_DELTA_W-1:0] v);
    logic [7:0] neg;
    neg = 8'd0 - {{2{v[QP_DELTA_W-1]}}, v};
    if (!v[QP_DELTA_W-1] && (v != '0)) begin
      se_code_num = {v, 1'b0} - 7'd1;
    end else begin
      se_code_num = {neg[5:0], 1'b0};
    end
  endfunction

endpackage

// File: rtl/exp_golomb_encoder.sv
// Combinational ue(v) Exp-Golomb encoder.
//   code_num : unsigned code number (0..64 used by the slice header)
//   codeword : codeword left-aligned in MAX_CW_LEN bits, zeros below
//   cw_len   : codeword length in bits (2L-1, L = bit length of code_num+1)
module exp_golomb_encoder
  import slice_codec_pkg::*;
(
  input  logic [CODE_NUM_W-1:0] code_num,
  output logic [MAX_CW_LEN-1:0] codeword,
  output logic [CW_LEN_W-1:0]   cw_len
);

  logic [7:0] n;
  logic [2:0] nbits;

  always_comb begin
    n     = {1'b0, code_num} + 8'd1;
    nbits = 3'd1;
    // Only bits 0..6 are searched: code numbers above 126 never occur.
    for (int unsigned i = 1; i < 7; i++) begin
      if (n[i]) nbits = 3'(i + 1);
    end
    cw_len   = {nbits, 1'b0} - 4'd1;
    // n right-aligned in cw_len bits already carries the L-1 leading zeros;
    // shifting it up left-aligns the whole codeword.
    codeword = {5'b0, n} << (4'(MAX_CW_LEN) - cw_len);
  end

endmodule

// File: rtl/slice_encoder.sv
// Slice-layer bitstream writer: Exp-Golomb header, byte payload, RBSP
// trailing bits, emitted as a byte stream toward the NAL packer.
// Optional macro SLICE_ENC_EMULATION_PREV_EN inserts 0x03 after two 0x00
// bytes when the next byte is <= 0x03.
//   clk, reset                  : clock, synchronous active-high reset
//   start / slice_type / num_ref_idx_l0_active_minus1 /
//   num_ref_idx_l1_active_minus1 / slice_qp_delta : header fields, latched on start in IDLE
//   in_data/in_valid/in_last/in_ready     : payload byte stream in
//   out_data/out_valid/out_last/out_ready : encoded byte stream out
//   busy  : high outside IDLE
//   done  : pulse after the final byte is accepted
//   error : pulse on start with an illegal slice type
module slice_encoder
  import slice_codec_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] slice_type,
  input  logic [2:0] num_ref_idx_l0_active_minus1,
  input  logic [2:0] num_ref_idx_l1_active_minus1,
  input  logic [5:0] slice_qp_delta,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] ACC_LIM = SUM_W'(ACC_W);
  localparam logic [CNT_W-1:0] IN_LIM  = CNT_W'(ACC_W - 8);
  localparam logic [CNT_W-1:0] BYTE_W  = CNT_W'(8);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_TRAIL,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    FLD_TYPE,
    FLD_L0,
    FLD_L1,
    FLD_QP
  } hdr_fld_e;

  state_e      state;
  hdr_fld_e    fld;
  slice_type_e type_q;
  logic [2:0]  l0_q;
  logic [2:0]  l1_q;
  logic [5:0]  qp_q;

  // Valid bits are left-aligned: acc[ACC_W-1 -: count], zeros below.
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic [CODE_NUM_W-1:0] code_num;
  logic [MAX_CW_LEN-1:0] cw;
  logic [CW_LEN_W-1:0]   cw_len;

  logic [MAX_CW_LEN-1:0] app_bits;
  logic [CW_LEN_W-1:0]   app_len;
  logic [SUM_W-1:0]      fill;
  logic                  app_fits;
  logic                  app_en;

  logic [7:0]       top_byte;
  logic             insert;
  logic             fire;
  logic             emit;
  logic [CNT_W-1:0] base;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_next;

  exp_golomb_encoder u_eg (
    .code_num (code_num),
    .codeword (cw),
    .cw_len   (cw_len)
  );

  always_comb begin
    case (fld)
      FLD_TYPE: code_num = {5'b0, type_q};
      FLD_L0:   code_num = {4'b0, l0_q};
      FLD_L1:   code_num = {4'b0, l1_q};
      default:  code_num = se_code_num(qp_q);
    endcase
  end

  assign in_ready = (state == ST_DATA) && (count <= IN_LIM);

  always_comb begin
    app_bits = '0;
    app_len  = '0;
    case (state)
      ST_HDR: begin
        app_bits = cw;
        app_len  = cw_len;
      end
      ST_DATA: begin
        app_bits = {in_data, 5'b0};
        app_len  = 4'd8;
      end
      ST_TRAIL: begin
        // Stop bit plus P zeros, P = (8 - (count+1) mod 8) mod 8 = ~count[2:0].
        app_bits = {1'b1, 12'b0};
        app_len  = {1'b0, ~count[2:0]} + 4'd1;
      end
      default: ;
    endcase
    fill     = {1'b0, count} + SUM_W'(app_len);
    app_fits = (fill <= ACC_LIM);
    case (state)
      ST_HDR, ST_TRAIL: app_en = app_fits;
      ST_DATA:          app_en = in_valid && in_ready;
      default:          app_en = 1'b0;
    endcase
  end

  assign top_byte  = acc[ACC_W-1 -: 8];
  assign out_valid = (count >= BYTE_W);
  assign busy      = (state != ST_IDLE);

`ifdef SLICE_ENC_EMULATION_PREV_EN
  logic [1:0] zero_run;
  assign insert = out_valid && (zero_run == 2'd2) && (top_byte <= EPB_BYTE);
`else
  assign insert = 1'b0;
`endif

  assign out_data = insert ? EPB_BYTE : top_byte;
  assign out_last = (state == ST_DRAIN) && (count == BYTE_W) && !insert;
  assign fire     = out_valid && out_ready;
  // An inserted byte is emitted without consuming accumulator bits.
  assign emit     = fire && !insert;

  // Append position is relative to the post-emit count so that a
  // simultaneous emit and append land the new bits directly after the
  // remaining ones.
  always_comb begin
    base       = emit ? (count - BYTE_W) : count;
    acc_next   = (emit ? {acc[ACC_W-9:0], 8'h00} : acc)
               | (app_en ? ({app_bits, {(ACC_W-MAX_CW_LEN){1'b0}}} >> base) : '0);
    count_next = count + (app_en ? CNT_W'(app_len) : '0) - (emit ? BYTE_W : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      fld    <= FLD_TYPE;
      type_q <= SLICE_P;
      l0_q   <= '0;
      l1_q   <= '0;
      qp_q   <= '0;
      acc    <= '0;
      count  <= '0;
      done   <= 1'b0;
      error  <= 1'b0;
`ifdef SLICE_ENC_EMULATION_PREV_EN
      zero_run <= '0;
`endif
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      acc   <= acc_next;
      count <= count_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (slice_type == SLICE_TYPE_ILLEGAL) begin
              error <= 1'b1;
            end else begin
              type_q <= slice_type_e'(slice_type);
              l0_q   <= num_ref_idx_l0_active_minus1;
              l1_q   <= num_ref_idx_l1_active_minus1;
              qp_q   <= slice_qp_delta;
              fld    <= FLD_TYPE;
              state  <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (app_en) begin
            case (fld)
              FLD_TYPE: fld <= (type_q == SLICE_I) ? FLD_QP : FLD_L0;
              FLD_L0:   fld <= (type_q == SLICE_B) ? FLD_L1 : FLD_QP;
              FLD_L1:   fld <= FLD_QP;
              default:  state <= ST_DATA;
            endcase
          end
        end
        ST_DATA: begin
          if (app_en && in_last) state <= ST_TRAIL;
        end
        ST_TRAIL: begin
          if (app_en) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (fire && out_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef SLICE_ENC_EMULATION_PREV_EN
      if ((state == ST_IDLE) && start) begin
        zero_run <= '0;
      end else if (fire) begin
        zero_run <= (insert || (out_data != 8'h00)) ? 2'd0 : zero_run + 2'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_slice_encoder.sv
// Scoreboard bench for slice_encoder: stimulus pushes expected bytes into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_slice_encoder;
  import slice_codec_pkg::*;

  localparam int unsigned ACC_W = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] slice_type;
  logic [2:0] l0, l1;
  logic [5:0] qp;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last, busy, done, error;

  always #5 clk = ~clk;

  slice_encoder #(.ACC_W(ACC_W)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .start                        (start),
    .slice_type                   (slice_type),
    .num_ref_idx_l0_active_minus1 (l0),
    .num_ref_idx_l1_active_minus1 (l1),
    .slice_qp_delta               (qp),
    .in_data                      (in_data),
    .in_valid                     (in_valid),
    .in_last                      (in_last),
    .in_ready                     (in_ready),
    .out_data                     (out_data),
    .out_valid                    (out_valid),
    .out_ready                    (out_ready),
    .out_last                     (out_last),
    .busy                         (busy),
    .done                         (done),
    .error                        (error)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] pay[$];
  bit         mbits[$];
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: bit list built straight from the Exp-Golomb rules.
  function automatic void put_ue(input int unsigned k);
    int unsigned n, len;
    n = k + 1;
    len = 0;
    while ((n >> len) != 0) len++;
    for (int unsigned z = 1; z < len; z++) mbits.push_back(1'b0);
    for (int i = int'(len) - 1; i >= 0; i--) mbits.push_back(n[i]);
  endfunction

  function automatic void build_expected(input int t, input int a, input int b, input int q);
    int nbytes;
    int zr;
    logic [7:0] by;
    mbits.delete();
    put_ue(32'(t));
    if (t != 2) put_ue(32'(a));
    if (t == 1) put_ue(32'(b));
    put_ue(32'((q > 0) ? (2 * q - 1) : (-2 * q)));
    foreach (pay[i]) for (int k = 7; k >= 0; k--) mbits.push_back(pay[i][k]);
    mbits.push_back(1'b1);
    while ((mbits.size() % 8) != 0) mbits.push_back(1'b0);
    nbytes = mbits.size() / 8;
    zr = 0;
    for (int i = 0; i < nbytes; i++) begin
      by = '0;
      for (int k = 0; k < 8; k++) by = {by[6:0], mbits[8*i+k]};
`ifdef SLICE_ENC_EMULATION_PREV_EN
      if (zr == 2 && by <= 8'h03) begin
        expq.push_back('{data: 8'h03, last: 1'b0});
        zr = 0;
      end
      zr = (by == 8'h00) ? zr + 1 : 0;
`endif
      expq.push_back('{data: by, last: (i == nbytes - 1)});
    end
  endfunction

  task automatic push_dir(input logic [7:0] d, input logic last);
    expq.push_back('{data: d, last: last});
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic held, hl;
    logic [7:0] hd;
    exp_t e;
    held = 1'b0; hd = '0; hl = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          check("done_after_last", 32'(expq.size()), 32'd0);
        end
        if (held) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(hd));
          check("hold_last", 32'(out_last), 32'(hl));
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_byte: got %02h, expected no output (t=%0t)", out_data, $time);
          end else begin
            e = expq.pop_front();
            check("out_data", 32'(out_data), 32'(e.data));
            check("out_last", 32'(out_last), 32'(e.last));
          end
        end
        held = out_valid && !out_ready;
        hd = out_data;
        hl = out_last;
      end
    end
  end

  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic do_start(input logic [1:0] t, input logic [2:0] a, input logic [2:0] b,
                          input logic [5:0] q);
    int guard = 0;
    while (busy && guard < 300) begin @(posedge clk); #1; guard++; end
    check("idle_before_start", 32'(busy), 32'd0);
    slice_type = t; l0 = a; l1 = b; qp = q; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    slice_type = 2'($urandom); l0 = 3'($urandom); l1 = 3'($urandom); qp = 6'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int guard = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard >= 400) break;
    end
    check("in_accept_in_time", 32'(guard < 400), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic wait_done(input int d0);
    int guard = 0;
    while (done_cnt == d0 && guard < 2000) begin @(posedge clk); #1; guard++; end
    repeat (4) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("stream_complete", 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic send_payload();
    foreach (pay[i]) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(pay[i], (i == pay.size() - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  task automatic run_test1();
    int d0;
    push_dir(8'h7A, 1'b0);
    push_dir(8'h58, 1'b1);
    d0 = done_cnt;
    do_start(2'd2, 3'd0, 3'd0, 6'd0);
    send_byte(8'hA5, 1'b1);
    wait_done(d0);
  endtask

  initial begin : stim
    int d0;
    int t, n, r;
    logic [2:0] a, b;
    logic [5:0] q;
    bit poke;

    reset = 1'b1; start = 1'b0; slice_type = '0; l0 = '0; l1 = '0; qp = '0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: I slice, qp 0, {A5}
    rdy_mode = 0;
    run_test1();

    // 2: P slice, l0=1, qp=-1, {FF}
    push_dir(8'hA7, 1'b0);
    push_dir(8'hFF, 1'b1);
    d0 = done_cnt;
    do_start(2'd0, 3'd1, 3'd0, 6'h3F);
    send_byte(8'hFF, 1'b1);
    wait_done(d0);

    // 3: B slice, qp=+1, {00,00,01}
    push_dir(8'h5A, 1'b0);
    push_dir(8'h00, 1'b0);
    push_dir(8'h00, 1'b0);
`ifdef SLICE_ENC_EMULATION_PREV_EN
    push_dir(8'h03, 1'b0);
`endif
    push_dir(8'h01, 1'b0);
    push_dir(8'h80, 1'b1);
    d0 = done_cnt;
    do_start(2'd1, 3'd0, 3'd0, 6'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b1);
    wait_done(d0);

    // 4a: test 1 with output stalled for 5 cycles mid-stream
    rdy_mode = 2;
    push_dir(8'h7A, 1'b0);
    push_dir(8'h58, 1'b1);
    d0 = done_cnt;
    do_start(2'd2, 3'd0, 3'd0, 6'd0);
    send_byte(8'hA5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rdy_mode = 0;
    wait_done(d0);

    // 4b: accumulator fills up while the output is blocked
    rdy_mode = 2;
    @(posedge clk); #1;
    pay.delete();
    pay.push_back(8'h11); pay.push_back(8'h22); pay.push_back(8'h33);
    pay.push_back(8'h44); pay.push_back(8'h55);
    build_expected(2, 0, 0, 0);
    d0 = done_cnt;
    do_start(2'd2, 3'd0, 3'd0, 6'd0);
    for (int i = 0; i < 4; i++) send_byte(pay[i], 1'b0);
    in_data = 8'h55; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("in_ready_full", 32'(in_ready), 32'd0);
    end
    check("out_valid_blocked", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rdy_mode = 0;
    send_byte(8'h55, 1'b1);
    wait_done(d0);

    // 5: illegal slice type, then start while busy
    slice_type = 2'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("error_pulse", 32'(error), 32'd1);
    check("error_busy", 32'(busy), 32'd0);
    check("error_no_output", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("error_one_cycle", 32'(error), 32'd0);
    check("error_still_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    pay.delete();
    pay.push_back(8'hC3); pay.push_back(8'h3C);
    build_expected(0, 5, 0, int'($signed(6'h30)));
    d0 = done_cnt;
    do_start(2'd0, 3'd5, 3'd0, 6'h30);
    slice_type = 2'd1; l0 = 3'd2; l1 = 3'd7; qp = 6'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_payload();
    wait_done(d0);

    // 6: reset during DATA, then rerun test 1
    rdy_mode = 2;
    @(posedge clk); #1;
    do_start(2'd2, 3'd0, 3'd0, 6'd0);
    send_byte(8'hA5, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rdy_mode = 0;
    run_test1();

    // Randomised slices against the model
    for (int it = 0; it < 40; it++) begin
      t = $urandom_range(0, 2);
      a = 3'($urandom);
      b = 3'($urandom);
      q = (it == 0) ? 6'h20 : (it == 1) ? 6'h1F : 6'($urandom);
      n = $urandom_range(1, 7);
      pay.delete();
      repeat (n) begin
        r = $urandom_range(0, 9);
        if (r < 4)      pay.push_back(8'h00);
        else if (r < 6) pay.push_back(8'($urandom_range(0, 3)));
        else            pay.push_back(8'($urandom));
      end
      poke = ($urandom_range(0, 4) == 0);
      rdy_mode = $urandom_range(0, 1);
      build_expected(t, int'(a), int'(b), int'($signed(q)));
      d0 = done_cnt;
      do_start(2'(t), a, b, q);
      if (poke) begin
        slice_type = 2'd1; l0 = ~a; l1 = ~b; qp = ~q; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_payload();
      wait_done(d0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
